// File: rtl/pwm_comp_gen.sv
// Centre-aligned PWM comparator generator: turns a 0..STEPS duty code into a
// pulse that is high duty/2 steps at the start of each period and the rest at the end.
module pwm_comp_gen #(
    parameter int WIDTH    = 7,
    parameter int STEPS    = 100,
    parameter int TICK_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             comp,
    output logic             period_start,
    output logic [WIDTH-1:0] active_duty
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CW = ((SW > WIDTH) ? SW : WIDTH) + 1;

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(STEPS - 1);
    localparam logic [WIDTH-1:0] STEPS_W   = WIDTH'(STEPS);
    localparam logic [CW-1:0]    STEPS_X   = CW'(STEPS);

    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic             started_q, started_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             comp_q, comp_d;
    logic             period_start_q, period_start_d;

    logic             boundary;
    logic             transfer;
    logic [WIDTH-1:0] duty_clamped;
    logic [CW-1:0]    step_x, lo_x, hi_x;

    assign boundary     = started_q && (tick_cnt_q == TICK_LAST) && (step_cnt_q == STEP_LAST);
    assign transfer     = duty_valid && !shadow_full_q;
    assign duty_clamped = (duty_in > STEPS_W) ? STEPS_W : duty_in;

    // Period timebase. The first clock after reset release is held at count 0
    // so that period_start marks a full-length first period.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which is what keeps this block free of latches.
        tick_cnt_d     = tick_cnt_q;
        step_cnt_d     = step_cnt_q;
        started_d      = started_q;
        period_start_d = 1'b0;
        if (!started_q) begin
            started_d      = 1'b1;
            period_start_d = 1'b1;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d     = '0;
                period_start_d = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + SW'(1);
            end
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Shadow register and boundary load. A full shadow keeps ready low, so a
    // load and a new transfer can never coincide.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        if (boundary && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end else if (transfer) begin
            shadow_d      = duty_clamped;
            shadow_full_d = 1'b1;
        end
    end

    // Comparator is evaluated on next-state values so comp_q lines up with
    // step_cnt_q and active_q; odd duties put the extra step at the end.
    always_comb begin
        step_x = CW'(step_cnt_d);
        lo_x   = CW'(active_d >> 1);
        hi_x   = CW'(active_d) - lo_x;
        comp_d = (step_x < lo_x) || (step_x >= (STEPS_X - hi_x));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q     <= '0;
            step_cnt_q     <= '0;
            started_q      <= 1'b0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            active_q       <= '0;
            comp_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            step_cnt_q     <= step_cnt_d;
            started_q      <= started_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            active_q       <= active_d;
            comp_q         <= comp_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = !shadow_full_q;
    assign comp         = comp_q;
    assign period_start = period_start_q;
    assign active_duty  = active_q;

endmodule
